approx_adder_pipe_et: RTL and testbench
=======================================

APPROX_ADDER_PIPE_ET -- requirements
Module: approx_adder_pipe_et

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter K, default 2: number of approximated low-order bits, legal range 0..WIDTH.
REQ-003 SHALL have parameter ET, default 1: error threshold, unsigned.
REQ-004 SHALL have parameter STAGES, default 2: pipeline depth, legal range 1..4.
REQ-005 SHALL have parameter CW, default 16: statistics counter width.
REQ-006 SHALL have one clock and a synchronous, active-high reset, port list in this order:
- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- exact_mode  in  1  forces the exact sum; sampled with the operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  approximate (or exact) sum.
- out_err  out  WIDTH+1  |exact - out_sum|.
- out_viol  out  1  out_err > ET.
- clr_stats  in  1  clears the statistics counters and register.
- cnt_total  out  CW  results delivered.
- cnt_viol  out  CW  violating results delivered.
- err_max  out  WIDTH+1  largest out_err delivered.

Function
REQ-007 SHALL compute the approximate sum (lower-part OR) as follows:
- lo = a[K-1:0] | b[K-1:0].
- c = a[K-1] & b[K-1].
- hi = a[WIDTH-1:K] + b[WIDTH-1:K] + c.
- out_sum = {hi, lo}.
REQ-008 SHALL produce the exact sum a+b when K=0 or exact_mode=1, with out_err=0 and out_viol=0.
REQ-009 SHALL compute the exact sum, out_err and out_viol in the same pipeline as out_sum, aligned with it.
REQ-010 SHALL accept an operand pair on any cycle where in_valid & in_ready.
REQ-011 SHALL deliver a result on any cycle where out_valid & out_ready.
REQ-012 SHALL present a result at out_valid exactly STAGES cycles after acceptance when the output is not stalled.
REQ-013 SHALL drive in_ready = ~(out_valid & ~out_ready), i.e. a global stall; all stages hold while stalled.
REQ-014 SHALL keep out_sum, out_err and out_viol stable while out_valid=1 and out_ready=0.
REQ-015 SHALL carry one valid bit per stage; bubbles propagate and stage data is don't-care when its valid bit is 0.
REQ-016 SHALL sustain one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-017 SHALL update the statistics only on an output handshake:
- cnt_total increments by 1.
- cnt_viol increments by 1 if out_viol=1.
- err_max takes max(err_max, out_err).
REQ-018 SHALL saturate both counters at 2^CW-1 with no wrap.
REQ-019 SHALL give clr_stats priority over a simultaneous handshake: the counters and err_max clear to 0 and that handshake is not counted.
REQ-020 SHALL leave the pipeline unaffected by clr_stats.
REQ-021 SHALL hold each stage's exact_mode bit with its data, so a mode change mid-stream affects only newly accepted pairs.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, clear all stage valid bits, out_valid, cnt_total, cnt_viol and err_max to 0.
REQ-023 SHALL drive out_sum, out_err and out_viol to 0 at reset.
REQ-024 SHALL drive in_ready=1 from the first cycle after reset.
REQ-025 SHALL discard in-flight data when reset is asserted mid-operation, with no result emitted for it.
REQ-026 SHALL give rst priority over clr_stats and over all handshakes.

Verification
REQ-027 (WIDTH=4, K=2, ET=1) SHALL cover these pairs, giving out_sum/out_err/out_viol:
- a=3, b=1 -> 3/1/0.
- a=3, b=3 -> 7/1/0.
- a=2, b=2 -> 6/2/1.
- a=15, b=15 -> 31/1/0.
REQ-028 SHALL cover a=2, b=2 with exact_mode=1 -> out_sum=4, out_err=0, out_viol=0.
REQ-029 SHALL cover STAGES=2 with 8 back-to-back pairs and out_ready=1:
- first result 2 cycles after the first accept.
- 8 results on consecutive cycles.
- cnt_total=8.
REQ-030 SHALL cover holding out_ready=0 for 5 cycles mid-stream:
- in_ready=0 throughout the stall.
- output held stable.
- no loss or duplication; order preserved.
REQ-031 SHALL cover clr_stats asserted in the same cycle as a violating handshake -> cnt_total=0, cnt_viol=0, err_max=0 on the next cycle.
REQ-032 SHALL cover counter saturation and mid-stream reset:
- CW=4 with 20 violating results -> cnt_viol=15 and cnt_total=15.
- rst asserted with 2 pairs in flight -> no out_valid afterwards, counters 0.

Source files
------------

// File: rtl/approx_adder_pipe_et.sv
// approx_adder_pipe_et: lower-part-OR approximate adder with error tracking, stallable pipeline and statistics
module approx_adder_pipe_et #(
   parameter int          WIDTH  = 4,
   parameter int          K      = 2,
   parameter int unsigned ET     = 1,
   parameter int          STAGES = 2,
   parameter int          CW     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             exact_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_err,
   output logic             out_viol,
   input  logic             clr_stats,
   output logic [CW-1:0]    cnt_total,
   output logic [CW-1:0]    cnt_viol,
   output logic [WIDTH:0]   err_max
);
   localparam int KM = (K > 0) ? K - 1 : 0;
   localparam logic [WIDTH:0] MASK = (WIDTH+1)'((64'd1 << K) - 64'd1);

   logic             r_v    [STAGES];
   logic [WIDTH:0]   r_sum  [STAGES];
   logic [WIDTH:0]   r_err  [STAGES];
   logic             r_viol [STAGES];
   logic [WIDTH:0]   w_ae, w_be, w_exact, w_approx, w_sum, w_err;
   logic             w_c, w_viol, w_en, w_hs;

   // Exact and approximate sums are formed at entry so the mode bit travels implicitly with its data
   always_comb begin
      w_ae     = {1'b0, in_a};
      w_be     = {1'b0, in_b};
      w_exact  = w_ae + w_be;
      w_c      = (K > 0) && in_a[KM] && in_b[KM];
      w_approx = (((w_ae >> K) + (w_be >> K) + {{WIDTH{1'b0}}, w_c}) << K) | ((w_ae | w_be) & MASK);
      w_sum    = (exact_mode || K == 0) ? w_exact : w_approx;
      w_err    = (w_exact >= w_sum) ? w_exact - w_sum : w_sum - w_exact;
      w_viol   = 64'(w_err) > 64'(ET);
   end

   assign w_en      = ~(r_v[STAGES-1] & ~out_ready);
   assign in_ready  = w_en;
   assign out_valid = r_v[STAGES-1];
   assign out_sum   = r_sum[STAGES-1];
   assign out_err   = r_err[STAGES-1];
   assign out_viol  = r_viol[STAGES-1];
   assign w_hs      = out_valid & out_ready;

   // Pipeline shift; every stage holds when the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_v[i]    <= 1'b0;
            r_sum[i]  <= '0;
            r_err[i]  <= '0;
            r_viol[i] <= 1'b0;
         end
      end else if (w_en) begin
         r_v[0]    <= in_valid;
         r_sum[0]  <= w_sum;
         r_err[0]  <= w_err;
         r_viol[0] <= w_viol;
         for (int i = 1; i < STAGES; i++) begin
            r_v[i]    <= r_v[i-1];
            r_sum[i]  <= r_sum[i-1];
            r_err[i]  <= r_err[i-1];
            r_viol[i] <= r_viol[i-1];
         end
      end
   end

   // Saturating statistics updated on output handshakes; clear beats a simultaneous handshake
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         cnt_total <= '0;
         cnt_viol  <= '0;
         err_max   <= '0;
      end else if (w_hs) begin
         cnt_total <= (cnt_total == '1) ? cnt_total : cnt_total + CW'(1);
         cnt_viol  <= (out_viol && cnt_viol != '1) ? cnt_viol + CW'(1) : cnt_viol;
         err_max   <= (out_err > err_max) ? out_err : err_max;
      end
   end
endmodule

// File: tb/tb_approx_adder_pipe_et.sv
// tb_approx_adder_pipe_et: scoreboard bench with random and directed stimulus against an arithmetic model
module tb_approx_adder_pipe_et;
   localparam int WIDTH = 4, K = 2, ET = 1, STAGES = 2, CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [WIDTH:0] s;
      logic [WIDTH:0] e;
      logic           v;
   } exp_t;

   logic clk = 0, rst = 1, in_valid = 0, exact_mode = 0, out_ready = 1, clr_stats = 0;
   logic in_ready, out_valid, out_viol;
   logic [WIDTH-1:0] in_a = 0, in_b = 0;
   logic [WIDTH:0] out_sum, out_err, err_max;
   logic [CW-1:0] cnt_total, cnt_viol;

   exp_t sb[$];
   int acc_cyc[$], hs_cyc[$];
   int errors = 0, checks = 0, cyc = 0;
   int m_total = 0, m_viol = 0, m_max = 0;
   logic p_stall = 0, p_viol = 0;
   logic [WIDTH:0] p_sum = 0, p_err = 0;
   logic rnd_on = 0;

   approx_adder_pipe_et #(.WIDTH(WIDTH), .K(K), .ET(ET), .STAGES(STAGES), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .exact_mode(exact_mode), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_err(out_err), .out_viol(out_viol), .clr_stats(clr_stats), .cnt_total(cnt_total),
      .cnt_viol(cnt_viol), .err_max(err_max)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input int a, input int b, input logic m);
      exp_t r;
      int ex, lo, c, ap, er;
      ex = a + b;
      lo = (a % (1 << K)) | (b % (1 << K));
      c  = ((a >> (K - 1)) & 1) & ((b >> (K - 1)) & 1);
      ap = ((a >> K) + (b >> K) + c) * (1 << K) + lo;
      if (m) ap = ex;
      er = (ex > ap) ? ex - ap : ap - ex;
      r.s = ap[WIDTH:0];
      r.e = er[WIDTH:0];
      r.v = er > ET;
      return r;
   endfunction

   // Monitor: checks statistics, stall behaviour, and pops the scoreboard on each handshake
   always @(negedge clk) begin
      if (!rst) begin
         chk("cnt_total", cnt_total, m_total);
         chk("cnt_viol", cnt_viol, m_viol);
         chk("err_max", err_max, m_max);
         if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
         if (p_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, p_sum);
            chk("hold_err", out_err, p_err);
            chk("hold_viol", out_viol, p_viol);
         end
      end
      if (rst) begin
         sb.delete();
         m_total = 0; m_viol = 0; m_max = 0;
         p_stall = 0;
      end else begin
         if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_sum", out_sum, e.s);
               chk("out_err", out_err, e.e);
               chk("out_viol", out_viol, e.v);
               if (!clr_stats) begin
                  if (m_total < CMAX) m_total++;
                  if (e.v && m_viol < CMAX) m_viol++;
                  if (int'(e.e) > m_max) m_max = int'(e.e);
               end
            end
         end
         if (clr_stats) begin
            m_total = 0; m_viol = 0; m_max = 0;
         end
         p_stall = out_valid && !out_ready;
         p_sum = out_sum; p_err = out_err; p_viol = out_viol;
      end
   end

   // Random backpressure used only during the random phase
   always @(posedge clk) if (rnd_on) out_ready <= #1 ($urandom_range(0, 3) != 0);

   task automatic send(input int a, input int b, input logic m, input logic dir, input exp_t de);
      in_valid = 1; in_a = a[WIDTH-1:0]; in_b = b[WIDTH-1:0]; exact_mode = m;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            sb.push_back(dir ? de : model(a, b, m));
            acc_cyc.push_back(cyc);
            break;
         end
         if (t == 100) begin
            chk("accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic clr_pulse();
      clr_stats = 1;
      @(posedge clk); #1;
      clr_stats = 0;
   endtask

   exp_t z = '{0, 0, 0};

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_viol", out_viol, 0);
      @(posedge clk); #1;

      send(3, 1, 0, 1, '{5'd3, 5'd1, 1'b0});
      send(3, 3, 0, 1, '{5'd7, 5'd1, 1'b0});
      send(2, 2, 0, 1, '{5'd6, 5'd2, 1'b1});
      send(15, 15, 0, 1, '{5'd31, 5'd1, 1'b0});
      send(2, 2, 1, 1, '{5'd4, 5'd0, 1'b0});
      drain();

      clr_pulse();
      acc_cyc.delete(); hs_cyc.delete();
      for (int i = 0; i < 8; i++) send($urandom_range(0, 15), $urandom_range(0, 15), 0, 0, z);
      drain();
      @(negedge clk);
      chk("burst_count", hs_cyc.size(), 8);
      if (hs_cyc.size() == 8 && acc_cyc.size() == 8) begin
         chk("burst_latency", hs_cyc[0] - acc_cyc[0], STAGES);
         for (int i = 1; i < 8; i++) chk("burst_consecutive", hs_cyc[i] - hs_cyc[0], i);
      end
      chk("burst_cnt_total", cnt_total, 8);
      @(posedge clk); #1;

      fork
         for (int i = 0; i < 10; i++) send($urandom_range(0, 15), $urandom_range(0, 15), i[0], 0, z);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();

      out_ready = 0;
      send(2, 2, 0, 0, z);
      for (int t = 0; !out_valid && t < 20; t++) begin
         @(posedge clk); #1;
      end
      chk("clr_precond_cnt", cnt_total != 0, 1);
      out_ready = 1; clr_stats = 1;
      @(posedge clk); #1;
      clr_stats = 0;
      @(negedge clk);
      chk("clr_cnt_total", cnt_total, 0);
      chk("clr_cnt_viol", cnt_viol, 0);
      chk("clr_err_max", err_max, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) send(2, 2, 0, 0, z);
      drain();
      @(negedge clk);
      chk("sat_cnt_viol", cnt_viol, 15);
      chk("sat_cnt_total", cnt_total, 15);
      chk("sat_err_max", err_max, 2);
      @(posedge clk); #1;

      rnd_on = 1;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) == 0, 0, z);
      end
      rnd_on = 0;
      @(posedge clk); #1;
      out_ready = 1;
      drain();

      send(1, 1, 0, 0, z);
      send(3, 2, 0, 0, z);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_valid", out_valid, 0);
      end
      chk("post_rst_cnt_total", cnt_total, 0);
      chk("post_rst_cnt_viol", cnt_viol, 0);
      chk("post_rst_err_max", err_max, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
